// File: rtl/bcd_timer_mux.sv
// rtl/bcd_timer_mux.sv - BCD up/down timer with preset/reload and multiplexed 7-segment scan
module bcd_timer_mux #(
    parameter int                  DIGITS      = 3,
    parameter int                  TICK_EXP    = 21,
    parameter int                  SCAN_EXP    = 17,
    parameter logic [4*DIGITS-1:0] RESET_VALUE = 'h123,
    parameter bit                  AUTO_RELOAD = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   preset,
    input  logic                  blank_lz,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  carry,
    output logic [2:0]            seg7_sel,
    output logic [6:0]            seg7_out,
    output logic                  dpt_out,
    output logic                  led_com
);
    localparam int W = 4 * DIGITS;

    logic [TICK_EXP-1:0] tick_cnt;
    logic [SCAN_EXP-1:0] scan_cnt;
    logic                tick;
    logic                scan;
    logic [W-1:0]        reload_q;
    logic [W-1:0]        preset_clean;
    logic [W-1:0]        step_value;
    logic [W-1:0]        next_count;
    logic                chain;
    logic                at_terminal;
    logic [2:0]          idx;
    logic [3:0]          digit;
    logic                upper_nz;
    logic                blank;

    assign tick    = &tick_cnt;
    assign scan    = &scan_cnt;
    assign dpt_out = 1'b0;
    assign led_com = 1'b1;

    always_comb begin
        preset_clean = preset;
        for (int i = 0; i < DIGITS; i++) begin
            if (preset[4*i +: 4] > 4'd9) preset_clean[4*i +: 4] = 4'd0;
        end
    end

    // Ripple the carry/borrow through the digits; a chain surviving past the top digit means terminal count.
    always_comb begin
        step_value = count_bcd;
        chain      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (chain) begin
                if (up_dn) begin
                    if (count_bcd[4*i +: 4] == 4'd9) begin
                        step_value[4*i +: 4] = 4'd0;
                    end else begin
                        step_value[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
                        chain = 1'b0;
                    end
                end else begin
                    if (count_bcd[4*i +: 4] == 4'd0) begin
                        step_value[4*i +: 4] = 4'd9;
                    end else begin
                        step_value[4*i +: 4] = count_bcd[4*i +: 4] - 4'd1;
                        chain = 1'b0;
                    end
                end
            end
        end
        at_terminal = chain;
        if (!at_terminal)     next_count = step_value;
        else if (!AUTO_RELOAD) next_count = count_bcd;
        else if (up_dn)        next_count = '0;
        else                   next_count = reload_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt  <= '0;
            scan_cnt  <= '0;
            count_bcd <= RESET_VALUE;
            reload_q  <= RESET_VALUE;
            carry     <= 1'b0;
            seg7_sel  <= 3'd5;
        end else begin
            tick_cnt <= tick_cnt + TICK_EXP'(1);
            scan_cnt <= scan_cnt + SCAN_EXP'(1);
            carry    <= 1'b0;
            if (load) begin
                count_bcd <= preset_clean;
                reload_q  <= preset_clean;
            end else if (tick && enable) begin
                count_bcd <= next_count;
                carry     <= at_terminal;
            end
            if (scan) begin
                seg7_sel <= (seg7_sel == 3'(6 - DIGITS)) ? 3'd5 : seg7_sel - 3'd1;
            end
        end
    end

    // Digit shown is 5-sel; blanked when it and every digit above it are zero, except digit 0.
    always_comb begin
        idx      = 3'd5 - seg7_sel;
        digit    = 4'd0;
        upper_nz = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == 3'(i)) digit = count_bcd[4*i +: 4];
            if (3'(i) >= idx && count_bcd[4*i +: 4] != 4'd0) upper_nz = 1'b1;
        end
        blank = (blank_lz && idx != 3'd0 && !upper_nz) || (int'(idx) >= DIGITS);
        case (digit)
            4'd0:    seg7_out = 7'b1111110;
            4'd1:    seg7_out = 7'b0110000;
            4'd2:    seg7_out = 7'b1101101;
            4'd3:    seg7_out = 7'b1111001;
            4'd4:    seg7_out = 7'b0110011;
            4'd5:    seg7_out = 7'b1011011;
            4'd6:    seg7_out = 7'b1011111;
            4'd7:    seg7_out = 7'b1110000;
            4'd8:    seg7_out = 7'b1111111;
            4'd9:    seg7_out = 7'b1111011;
            default: seg7_out = 7'b0000000;
        endcase
        if (blank) seg7_out = 7'b0000000;
    end
endmodule

// File: doc/bcd_timer_mux.md
BCD_TIMER_MUX -- requirements
Module: bcd_timer_mux

Interface
REQ-001 SHALL provide parameter DIGITS, default 3, number of BCD digits (legal 1..6).
REQ-002 SHALL provide parameter TICK_EXP, default 21: the count strobe fires once every 2^TICK_EXP clk cycles.
REQ-003 SHALL provide parameter SCAN_EXP, default 17: the scan strobe fires once every 2^SCAN_EXP clk cycles.
REQ-004 SHALL provide parameter RESET_VALUE, default 'h123 (4*DIGITS bits, BCD): power-up count and reload value.
REQ-005 SHALL provide parameter AUTO_RELOAD, default 1: 1 = reload or wrap at terminal count; 0 = hold at terminal count.
REQ-006 Port `clk`, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-007 Port `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port `enable`, input, 1 bit: 1 = count; 0 = pause.
REQ-009 Port `up_dn`, input, 1 bit: 1 = count up; 0 = count down.
REQ-010 Port `load`, input, 1 bit: synchronous preset load.
REQ-011 Port `preset`, input, 4*DIGITS bits: BCD load value; digit 0 is bits [3:0].
REQ-012 Port `blank_lz`, input, 1 bit: 1 = blank leading zeros.
REQ-013 Port `count_bcd`, output, 4*DIGITS bits: current count.
REQ-014 Port `carry`, output, 1 bit: one-cycle terminal-count pulse.
REQ-015 Port `seg7_sel`, output, 3 bits: digit select; 3'b101 is the rightmost digit.
REQ-016 Port `seg7_out`, output, 7 bits: segments abcdefg, active high.
REQ-017 Port `dpt_out`, output, 1 bit: SHALL be tied 0.
REQ-018 Port `led_com`, output, 1 bit: SHALL be tied 1.

Function
REQ-019 Tick divider: TICK_EXP-bit free-running counter; tick is a 1-clk strobe while the counter is all-ones. No derived clocks.
REQ-020 Scan divider: SCAN_EXP-bit free-running counter; scan strobe generated the same way as the tick.
REQ-021 Priority per clk: load > (tick & enable) count step > hold.
REQ-022 Load: count_bcd and the reload register both take preset on the next edge, regardless of tick or enable.
REQ-023 Load sanitising: any preset digit > 9 SHALL be stored as 0.
REQ-024 Count step, up: digit 0 increments; a digit at 9 becomes 0 and carries into the next digit.
REQ-025 Count step, down: digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit.
REQ-026 Terminal count: all-9s when counting up; all-0s when counting down.
REQ-027 Step from terminal count, AUTO_RELOAD=1:
- up: wrap to all-0s.
- down: load the reload register.
REQ-028 Step from terminal count, AUTO_RELOAD=0: count holds at terminal count.
REQ-029 carry: high for exactly the one clk cycle after a step taken from terminal count, in both AUTO_RELOAD modes.
REQ-030 carry: SHALL never assert on load.
REQ-031 enable=0: count frozen; dividers keep running; a tick while paused is lost, not queued.
REQ-032 up_dn change: takes effect at the next step; no extra step is taken.
REQ-033 Scan: on each scan strobe, seg7_sel decrements. At 6-DIGITS it wraps to 3'b101.
REQ-034 Scan decode: seg7_sel value s displays digit index 5-s.
REQ-035 Segment patterns for digits 0-9:
- 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
- 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
REQ-036 Blanking: with blank_lz=1, any digit above the most significant nonzero digit outputs 0000000.
REQ-037 Digit 0 is never blanked; seg7_out is combinational from seg7_sel and count_bcd.

Reset
REQ-038 While reset=0 (asynchronous), the block SHALL force:
- count_bcd = RESET_VALUE; reload register = RESET_VALUE
- seg7_sel = 3'b101; carry = 0; both dividers = 0
REQ-039 Reset asserted mid-count SHALL abort the step with no carry; counting resumes from RESET_VALUE at the first tick after release.

Verification
(Bench parameters: TICK_EXP=2, SCAN_EXP=1, DIGITS=3.)
REQ-040 Down-count: reset, enable=1, up_dn=0 -> count goes 123,122,...,000, then 123. carry pulses once, one clk after leaving 000.
REQ-041 Up-count: load preset 'h997, up_dn=1 -> 998, 999, 000 with one carry pulse. With AUTO_RELOAD=0 -> count stays 999, one carry pulse.
REQ-042 Pause: enable=0 for 10 ticks at 045 -> count stays 045. enable=1 -> next tick gives 044.
REQ-043 Load priority: load=1 with preset 'h7A2 on a tick cycle -> count 702, no step that cycle, no carry.
REQ-044 Scan and blanking: count 007, blank_lz=1 -> seg7_sel cycles 101,100,011,101 with seg7_out 1110000, 0000000, 0000000. With blank_lz=0 -> the upper two digits show 1111110.
REQ-045 Async reset: assert reset between clk edges at count 050 -> outputs take reset values immediately. After release -> 123, then 122 at the first tick.
